// File: rtl/qarma_stream_ctrl.sv
// Streaming valid/ready front-end for the registered QARMA-64 cipher: key holding, latency tracking, result FIFO.
// Optional completed-result counter on stat_cnt is enabled by defining QARMA_STREAM_STATS_EN.
module qarma_stream_ctrl #(
    parameter int CIPHER_LAT = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_we,
    input  logic [127:0]     key_in,
    output logic             key_busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_enc,
    input  logic [63:0]      s_p,
    input  logic [63:0]      s_t,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_c,
    output logic [TAG_W-1:0] m_tag,
    output logic             cq_enc,
    output logic [127:0]     cq_k,
    output logic [63:0]      cq_p,
    output logic [63:0]      cq_t,
    input  logic [63:0]      cq_c,
    output logic [31:0]      stat_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;

    logic [127:0]     key_q;
    logic [CIPHER_LAT:0] vld;
    logic [TAG_W-1:0] tag_pipe [CIPHER_LAT+1];
    logic [63:0]      mem_c    [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    occ;
    logic [31:0]      used;
    logic             accept;
    logic             push;
    logic             pop;

    // Credits in use: every in-flight request already owns a FIFO slot.
    always_comb begin
        used = 32'(occ);
        for (int i = 0; i <= CIPHER_LAT; i++) begin
            used = used + 32'(vld[i]);
        end
    end

    assign s_ready  = used < 32'(FIFO_DEPTH);
    assign accept   = s_valid & s_ready;
    assign push     = vld[CIPHER_LAT];
    assign m_valid  = occ != '0;
    assign pop      = m_valid & m_ready;
    assign key_busy = used != 32'd0;
    assign cq_k     = key_q;
    assign m_c      = m_valid ? mem_c[rd_ptr]   : '0;
    assign m_tag    = m_valid ? mem_tag[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
        end else if (key_we && !key_busy) begin
            key_q <= key_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cq_enc <= 1'b0;
            cq_p   <= '0;
            cq_t   <= '0;
        end else if (accept) begin
            cq_enc <= s_enc;
            cq_p   <= s_p;
            cq_t   <= s_t;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i <= CIPHER_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            vld <= {vld[CIPHER_LAT-1:0], accept};
            if (accept) begin
                tag_pipe[0] <= s_tag;
            end
            for (int i = 1; i <= CIPHER_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_c[wr_ptr]   <= cq_c;
            mem_tag[wr_ptr] <= tag_pipe[CIPHER_LAT];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

`ifdef QARMA_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cnt <= '0;
        end else if (pop && stat_cnt != 32'hFFFF_FFFF) begin
            stat_cnt <= stat_cnt + 32'd1;
        end
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_qarma_stream_ctrl.sv
// Self-checking bench for qarma_stream_ctrl with a 2-stage stub cipher (C = P ^ T ^ K[63:0]).
// Expected stat_cnt depends on QARMA_STREAM_STATS_EN.
module tb_qarma_stream_ctrl;
    localparam int CIPHER_LAT = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
`ifdef QARMA_STREAM_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             key_we = 1'b0;
    logic [127:0]     key_in = '0;
    logic             key_busy;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             s_enc = 1'b0;
    logic [63:0]      s_p = '0;
    logic [63:0]      s_t = '0;
    logic [TAG_W-1:0] s_tag = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [63:0]      m_c;
    logic [TAG_W-1:0] m_tag;
    logic             cq_enc;
    logic [127:0]     cq_k;
    logic [63:0]      cq_p;
    logic [63:0]      cq_t;
    logic [63:0]      cq_c;
    logic [31:0]      stat_cnt;

    qarma_stream_ctrl #(.CIPHER_LAT(CIPHER_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in), .key_busy(key_busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_enc(s_enc), .s_p(s_p), .s_t(s_t), .s_tag(s_tag),
        .m_valid(m_valid), .m_ready(m_ready), .m_c(m_c), .m_tag(m_tag),
        .cq_enc(cq_enc), .cq_k(cq_k), .cq_p(cq_p), .cq_t(cq_t), .cq_c(cq_c), .stat_cnt(stat_cnt)
    );

    always #5 clk = ~clk;

    // Stub cipher: input register then output register, sharing rst.
    logic [63:0] stub_p, stub_t, stub_k, stub_c;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_p <= '0; stub_t <= '0; stub_k <= '0; stub_c <= '0;
        end else begin
            stub_p <= cq_p; stub_t <= cq_t; stub_k <= cq_k[63:0];
            stub_c <= stub_p ^ stub_t ^ stub_k;
        end
    end
    assign cq_c = stub_c;

    typedef struct {
        logic [63:0]      c;
        logic [TAG_W-1:0] tag;
        int               rdy;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] key_m;
    logic [31:0]  stat_m;
    logic         last_enc;
    logic [63:0]  last_p, last_t;
    int           cyc, checks, failures;

    task automatic checkValue(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic enc, input logic [63:0] p, input logic [63:0] t,
                                 input logic [TAG_W-1:0] tg, input logic mr, input logic kwe, input logic [127:0] kin);
        s_valid = v; s_enc = enc; s_p = p; s_t = t; s_tag = tg;
        m_ready = mr; key_we = kwe; key_in = kin;
        #1;
    endtask

    // Compares one cycle against the model, applies this cycle's transfers to it, then advances a clock.
    task automatic checkOutput();
        logic         exp_ready, exp_mvalid;
        logic [127:0] key_next;
        exp_t         item;
        exp_ready  = exp_q.size() < FIFO_DEPTH;
        exp_mvalid = exp_q.size() != 0 && exp_q[0].rdy <= cyc;
        checkValue("s_ready", s_ready, exp_ready);
        checkValue("m_valid", m_valid, exp_mvalid);
        checkValue("key_busy", key_busy, exp_q.size() != 0);
        checkValue("stat_cnt", stat_cnt, STATS_EN ? stat_m : 32'd0);
        checkValue("cq_k", cq_k, key_m);
        checkValue("cq_p", cq_p, last_p);
        checkValue("cq_t", cq_t, last_t);
        checkValue("cq_enc", cq_enc, last_enc);
        if (exp_mvalid) begin
            checkValue("m_c", m_c, exp_q[0].c);
            checkValue("m_tag", m_tag, exp_q[0].tag);
        end
        key_next = (key_we && exp_q.size() == 0) ? key_in : key_m;
        if (exp_mvalid && m_ready) begin
            void'(exp_q.pop_front());
            if (stat_m != 32'hFFFF_FFFF) stat_m++;
        end
        if (s_valid && exp_ready) begin
            // Result appears after the accept edge plus CIPHER_LAT+1 further edges.
            item.c   = s_p ^ s_t ^ key_next[63:0];
            item.tag = s_tag;
            item.rdy = cyc + CIPHER_LAT + 2;
            exp_q.push_back(item);
            last_p = s_p; last_t = s_t; last_enc = s_enc;
        end
        key_m = key_next;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic mr);
        repeat (n) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, mr, 1'b0, '0);
            checkOutput();
        end
    endtask

    task automatic modelReset();
        exp_q.delete();
        key_m = '0; stat_m = '0; last_p = '0; last_t = '0; last_enc = 1'b0;
    endtask

    int acc_cyc, first_cyc, acc_cnt, pop_cnt;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        modelReset();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        checkValue("reset_m_valid", m_valid, 1'b0);
        checkValue("reset_m_c", m_c, 64'd0);
        checkValue("reset_m_tag", m_tag, 4'd0);
        checkValue("reset_key_busy", key_busy, 1'b0);
        checkValue("reset_stat_cnt", stat_cnt, 32'd0);
        rst = 1'b1;
        #1;
        checkValue("post_reset_s_ready", s_ready, 1'b1);

        $display("[TB] test 1: single request");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 128'hFF);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 64'h0123456789ABCDEF, 64'h0000000000000F00, 4'd5, 1'b1, 1'b0, '0);
        acc_cyc = cyc;
        checkOutput();
        first_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
            if (m_valid && first_cyc < 0) begin
                first_cyc = cyc;
                checkValue("t1_m_c", m_c, 64'h0123456789ABC210);
                checkValue("t1_m_tag", m_tag, 4'd5);
            end
            checkOutput();
        end
        // Window after the accept edge is acc_cyc+1; m_valid must come 3 edges later.
        checkValue("t1_latency", 32'(first_cyc - (acc_cyc + 1)), 32'd3);

        $display("[TB] test 2: back-to-back");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, '0);
        checkOutput();
        for (int i = 1; i <= 8; i++) begin
            for (int tries = 0; tries < 10; tries++) begin
                applyStimulus(1'b1, 1'b1, 64'(i), '0, TAG_W'(i), 1'b1, 1'b0, '0);
                if (s_ready) begin
                    checkOutput();
                    break;
                end
                checkOutput();
            end
        end
        idle(10, 1'b1);
        checkValue("t2_drained", key_busy, 1'b0);

        $display("[TB] test 3: backpressure");
        acc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 64'(100 + i), 64'h55, TAG_W'(i), 1'b0, 1'b0, '0);
            if (s_ready) acc_cnt++;
            checkOutput();
        end
        checkValue("t3_accepted", 32'(acc_cnt), 32'(FIFO_DEPTH));
        checkValue("t3_s_ready_low", s_ready, 1'b0);
        pop_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
            if (m_valid) pop_cnt++;
            checkOutput();
        end
        checkValue("t3_pops", 32'(pop_cnt), 32'(FIFO_DEPTH));

        $display("[TB] test 4: key update while busy");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 128'h1111);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 64'hA0, 64'h0, 4'd1, 1'b1, 1'b0, '0);
        checkOutput();
        applyStimulus(1'b1, 1'b0, 64'hA1, 64'h0, 4'd2, 1'b1, 1'b0, '0);
        checkOutput();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 128'h2222);
        checkOutput();
        checkValue("t4_key_kept", cq_k, 128'h1111);
        idle(6, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 128'h2222);
        checkOutput();
        checkValue("t4_key_new", cq_k, 128'h2222);
        applyStimulus(1'b1, 1'b1, 64'hB0, 64'h3, 4'd3, 1'b1, 1'b0, '0);
        checkOutput();
        idle(6, 1'b1);

        $display("[TB] test 5: reset mid-operation");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 64'(200 + i), 64'h9, TAG_W'(i), 1'b0, 1'b0, '0);
            checkOutput();
        end
        rst = 1'b0;
        #1;
        modelReset();
        checkValue("t5_m_valid", m_valid, 1'b0);
        checkValue("t5_key_busy", key_busy, 1'b0);
        checkValue("t5_cq_k", cq_k, 128'd0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkValue("t5_s_ready", s_ready, 1'b1);
        idle(6, 1'b1);

        $display("[TB] test 6: completion counter");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 64'(300 + i), 64'h0, TAG_W'(i), 1'b1, 1'b0, '0);
            if (!s_ready) i--;
            checkOutput();
        end
        idle(8, 1'b1);
        checkValue("t6_stat_cnt", stat_cnt, STATS_EN ? 32'd10 : 32'd0);

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                          TAG_W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          {$urandom, $urandom, $urandom, $urandom});
            checkOutput();
        end
        idle(10, 1'b1);
        checkValue("final_idle", key_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
